// File: rtl/pattern_stepper.sv
// Timed 2-bit pattern generator driving a downstream gate stage: holds each value DWELL cycles, STEPS increments per run.
// Define PATTERN_STEPPER_GRAY_EN for a Gray-code sequence; the default build steps in binary.
module pattern_stepper #(
  parameter int DWELL = 10,
  parameter int STEPS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic drv1,
  output logic drv2,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, PRE, STEP, DONE} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [7:0]  STEPS_L    = 8'(STEPS);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_dwell, w_dwell_nxt;
  logic [7:0]  r_steps, w_steps_nxt;
  logic [1:0]  r_pat,   w_pat_nxt;
  logic        r_busy,  w_busy_nxt;
  logic        r_done,  w_done_nxt;
  logic        w_dwell_end;

  function automatic logic [1:0] next_pat(input logic [1:0] p);
`ifdef PATTERN_STEPPER_GRAY_EN
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
`else
    return p + 2'd1;
`endif
  endfunction

  assign w_dwell_end = (r_dwell == DWELL_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_steps_nxt = r_steps;
    w_pat_nxt   = r_pat;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        // stop dominates a simultaneous start and clears the pattern
        if (start && stop) begin
          w_pat_nxt = 2'b00;
        end else if (start) begin
          w_state_nxt = PRE;
          w_busy_nxt  = 1'b1;
          w_pat_nxt   = 2'b00;
          w_dwell_nxt = 16'd0;
          w_steps_nxt = 8'd0;
        end
      end
      PRE, STEP: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_pat_nxt   = 2'b00;
          w_dwell_nxt = 16'd0;
          w_steps_nxt = 8'd0;
        end else if (w_dwell_end) begin
          w_dwell_nxt = 16'd0;
          // r_steps counts increments already applied; a run ends once all STEPS have dwelt
          if (r_steps == STEPS_L) begin
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = STEP;
            w_pat_nxt   = next_pat(r_pat);
            w_steps_nxt = r_steps + 8'd1;
          end
        end else begin
          w_dwell_nxt = r_dwell + 16'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dwell <= 16'd0;
      r_steps <= 8'd0;
      r_pat   <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      r_steps <= w_steps_nxt;
      r_pat   <= w_pat_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign drv1 = r_pat[1];
  assign drv2 = r_pat[0];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_pattern_stepper.sv
// Bench for pattern_stepper: three parameterisations share stimulus; each is checked against a
// time-offset reference model (pattern = sequence[(cycles since start / DWELL) mod 4]).
module tb_pattern_stepper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [2:0] w_drv1, w_drv2, w_busy, w_done;

  int n_cmp = 0;
  int n_err = 0;

  localparam int DW [3] = '{4, 3, 1};
  localparam int ST [3] = '{4, 0, 6};

  logic [1:0] SEQ [4];
  logic       m_act  [3];
  logic       m_done [3];
  logic [1:0] m_pat  [3];
  int         m_t    [3];

  always #5 clk = ~clk;

  pattern_stepper #(.DWELL(4), .STEPS(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .drv1(w_drv1[0]), .drv2(w_drv2[0]), .busy(w_busy[0]), .done(w_done[0]));
  pattern_stepper #(.DWELL(3), .STEPS(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .drv1(w_drv1[1]), .drv2(w_drv2[1]), .busy(w_busy[1]), .done(w_done[1]));
  pattern_stepper #(.DWELL(1), .STEPS(6)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .drv1(w_drv1[2]), .drv2(w_drv2[2]), .busy(w_busy[2]), .done(w_done[2]));

  function automatic logic [3:0] obs(input int i);
    return {w_busy[i], w_done[i], w_drv1[i], w_drv2[i]};
  endfunction

  function automatic logic [3:0] expv(input int i);
    return {m_act[i], m_done[i], m_pat[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_done[i] = 1'b0; m_pat[i] = 2'b00; m_t[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic s, input logic p);
    if (m_done[i]) begin
      m_done[i] = 1'b0;
      return;
    end
    if (m_act[i]) begin
      m_t[i]++;
      if (p) begin
        m_act[i] = 1'b0; m_pat[i] = 2'b00;
      end else if (m_t[i] == (ST[i] + 1) * DW[i]) begin
        m_act[i] = 1'b0; m_done[i] = 1'b1;
      end else begin
        m_pat[i] = SEQ[(m_t[i] / DW[i]) % 4];
      end
    end else if (s && p) begin
      m_pat[i] = 2'b00;
    end else if (s) begin
      m_act[i] = 1'b1; m_t[i] = 0; m_pat[i] = 2'b00;
    end
  endtask

  // drive inputs, advance one rising edge, update the model, then settle before sampling
  task automatic tick(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    if (rst) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i, s, p);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs(i) !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold inst%0d got %b want %b", i, obs(i), 4'b0000);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== 4'b0000) begin
          n_err++;
          $display("FAIL reset_start inst%0d got %b want %b", i, obs(i), 4'b0000);
        end
      end
    end
    #3 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_directed_run();
    tick(1'b1, 1'b0);
    for (int c = 0; c < 26; c++) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++;
          $display("FAIL run cyc%0d inst%0d got %b want %b", c, i, obs(i), expv(i));
        end
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_stop();
    tick(1'b1, 1'b0);
    for (int c = 1; c < 14; c++) begin
      tick(1'b0, c == 7);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++;
          $display("FAIL stop edge%0d inst%0d got %b want %b", c, i, obs(i), expv(i));
        end
      end
    end
    tick(1'b1, 1'b0);
    for (int c = 1; c < 24; c++) begin
      tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++;
          $display("FAIL stop_rerun edge%0d inst%0d got %b want %b", c, i, obs(i), expv(i));
        end
      end
    end
  endtask

  task automatic test_start_stop_idle();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs(i) !== 4'b0000) begin
        n_err++;
        $display("FAIL start_stop_idle inst%0d got %b want %b", i, obs(i), 4'b0000);
      end
    end
    tick(1'b1, 1'b0);
    for (int c = 1; c < 24; c++) begin
      tick(c == 9, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++;
          $display("FAIL start_busy edge%0d inst%0d got %b want %b", c, i, obs(i), expv(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0);
    for (int c = 1; c < 10; c++) tick(1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs(i) !== 4'b0000) begin
        n_err++;
        $display("FAIL async_rst inst%0d got %b want %b", i, obs(i), 4'b0000);
      end
    end
    model_reset();
    #2 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== 4'b0000) begin
          n_err++;
          $display("FAIL post_rst_idle cyc%0d inst%0d got %b want %b", c, i, obs(i), 4'b0000);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== expv(i)) begin
          n_err++;
          $display("FAIL random cyc%0d inst%0d got %b want %b", c, i, obs(i), expv(i));
        end
      end
    end
  endtask

  initial begin
`ifdef PATTERN_STEPPER_GRAY_EN
    SEQ = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    SEQ = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    model_reset();
    test_reset();
    test_directed_run();
    test_stop();
    test_start_stop_idle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_stepper.md
PATTERN_STEPPER -- requirements
Module: pattern_stepper

Interface
REQ-001 SHALL have parameter DWELL, default 10, meaning clock cycles each pattern value is held (legal range 1..65535).
REQ-002 SHALL have parameter STEPS, default 4, meaning pattern increments per run (legal range 0..255).
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  run request, sampled on a clk rising edge.
REQ-006 SHALL have port stop  input  1  synchronous abort request.
REQ-007 SHALL have port drv1  output  1  pattern MSB, feeds the downstream gate stage's in1.
REQ-008 SHALL have port drv2  output  1  pattern LSB, feeds the downstream gate stage's in2.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at normal run completion.
REQ-011 SHALL register all outputs, with no combinational path from any input to any output.

Function
REQ-012 SHALL implement the FSM states IDLE, PRE, STEP and DONE.
REQ-013 IDLE: busy=0 and done=0; {drv1,drv2} holds its last value.
REQ-014 IDLE with start=1 and stop=0 at edge k: the FSM SHALL go to PRE, set busy=1, set {drv1,drv2}=2'b00 and clear the dwell counter.
REQ-015 PRE SHALL hold 2'b00 for DWELL cycles, then go to STEP at edge k+DWELL, applying the first increment at that edge.
REQ-016 STEP SHALL increment the pattern every DWELL cycles, modulo 4 (11 -> 00 wraps), so increment n occurs at edge k+n*DWELL.
REQ-017 After increment STEPS, STEP SHALL hold that value DWELL cycles, then go to DONE at edge k+(STEPS+1)*DWELL.
REQ-018 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE; the pattern is unchanged.
REQ-019 When STEPS=0, PRE SHALL go directly to DONE after DWELL cycles, with the pattern remaining 2'b00.
REQ-020 The dwell counter SHALL be 16 bits and the step counter 8 bits; neither counter may wrap within a legal run.
REQ-021 start SHALL be ignored in PRE, STEP and DONE; there is no queuing or restart.
REQ-022 stop=1 in PRE or STEP SHALL, at the next edge, force IDLE, busy=0 and {drv1,drv2}=2'b00, with no done pulse.
REQ-023 When start and stop are both 1 in IDLE, stop SHALL win: the FSM stays in IDLE and the pattern is forced to 2'b00.
REQ-024 stop in DONE SHALL have no effect; done still pulses.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, counters SHALL be 0, and drv1=drv2=busy=done=0, independent of clk.
REQ-026 rst asserted mid-run SHALL abort immediately with no done pulse; after release, only a fresh start begins a run.
REQ-027 The first edge after rst deassertion SHALL sample start normally.

Configuration
REQ-028 SHALL support the macro PATTERN_STEPPER_GRAY_EN as the only compile-time option.
REQ-029 With PATTERN_STEPPER_GRAY_EN defined, the sequence SHALL be Gray code 00->01->11->10->00; otherwise it SHALL be binary 00->01->10->11->00.
REQ-030 Timing, handshake and reset behaviour SHALL be identical with and without PATTERN_STEPPER_GRAY_EN.

Verification
REQ-031 Binary run, DWELL=4, STEPS=4, start at edge 0 -> pattern 00 on edges 0-3, 01 on 4-7, 10 on 8-11, 11 on 12-15, 00 on 16-19; busy=1 on edges 0-19; done=1 only at edge 20.
REQ-032 Gray build, DWELL=2, STEPS=4 -> pattern 00, 01, 11, 10, 00, each held 2 cycles; done at edge 10.
REQ-033 STEPS=0, DWELL=3 -> pattern 00 throughout, busy for 3 cycles, done at edge 3.
REQ-034 stop at edge 6 of the REQ-031 run -> pattern 00, busy=0 from edge 7; done never asserts; a later start runs the full sequence.
REQ-035 start and stop both high in IDLE -> no run starts and the pattern is 00; start during busy at edge 9 -> the ongoing run's timing is unaltered.
REQ-036 rst pulse between clock edges at cycle 10 -> outputs go to 0 immediately; with no new start, the pattern stays 00 indefinitely.
